// File: rtl/countdown_timer.sv
// Loadable down counter: one-shot delay or periodic tick with a registered terminal-count pulse.
// The active-low asynchronous reset clears everything; a load restarts the count from load_val.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_auto_reload,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_expired,
  output logic             o_tc
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2} state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_count, w_count;
  logic [WIDTH-1:0] r_reload, w_reload;
  logic             r_expired, w_expired;
  logic             r_tc, w_tc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
      r_tc      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_count   <= w_count;
      r_reload  <= w_reload;
      r_expired <= w_expired;
      r_tc      <= w_tc;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_count   = r_count;
    w_reload  = r_reload;
    w_expired = r_expired;
    w_tc      = 1'b0;
    if (i_load) begin
      w_reload  = i_load_val;
      w_count   = i_load_val;
      w_expired = 1'b0;
      w_state   = (i_load_val != '0) ? RUN : IDLE;
    end else begin
      case (r_state)
        RUN: begin
          if (i_en) begin
            // Decrement happens only from 2 or more, so the counter never wraps.
            if (r_count > WIDTH'(1)) begin
              w_count = r_count - WIDTH'(1);
            end else begin
              w_tc = 1'b1;
              if (i_auto_reload) begin
                w_count = r_reload;
              end else begin
                w_count   = '0;
                w_state   = EXPIRED;
                w_expired = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count   = r_count;
  assign o_busy    = (r_state == RUN);
  assign o_expired = r_expired;
  assign o_tc      = r_tc;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expected outputs are queued with each stimulus step
// and popped for comparison one time unit after the following rising edge.
module tb_countdown_timer;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_load = 1'b0;
  logic [3:0] i_load_val = '0;
  logic       i_en = 1'b0;
  logic       i_auto_reload = 1'b0;
  logic [3:0] o_count;
  logic       o_busy, o_expired, o_tc;

  typedef struct packed {
    logic [3:0] c;
    logic       b;
    logic       e;
    logic       t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  countdown_timer #(.WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(i_load), .i_load_val(i_load_val),
    .i_en(i_en), .i_auto_reload(i_auto_reload), .o_count(o_count), .o_busy(o_busy),
    .o_expired(o_expired), .o_tc(o_tc)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag);
    exp_t x;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    x = q.pop_front();
    checks++;
    assert (o_count === x.c) else begin
      errors++; $error("FAIL %s count got %0d expected %0d", tag, o_count, x.c);
    end
    checks++;
    assert (o_busy === x.b) else begin
      errors++; $error("FAIL %s busy got %b expected %b", tag, o_busy, x.b);
    end
    checks++;
    assert (o_expired === x.e) else begin
      errors++; $error("FAIL %s expired got %b expected %b", tag, o_expired, x.e);
    end
    checks++;
    assert (o_tc === x.t) else begin
      errors++; $error("FAIL %s tc got %b expected %b", tag, o_tc, x.t);
    end
  endtask

  task automatic step(input logic ld, input logic [3:0] lv, input logic e, input logic ar,
                      input logic [3:0] c, input logic b, input logic ee, input logic t,
                      input string tag);
    exp_t x;
    i_load = ld; i_load_val = lv; i_en = e; i_auto_reload = ar;
    x.c = c; x.b = b; x.e = ee; x.t = t;
    q.push_back(x);
    @(posedge i_clk);
    #1;
    chk(tag);
  endtask

  initial begin
    exp_t x;
    logic [1:0] en_seq [6];
    logic [3:0] cexp;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    x = '{c: 4'd0, b: 1'b0, e: 1'b0, t: 1'b0};
    q.push_back(x);
    chk("reset");
    i_rst_n = 1'b1;

    // Reset mid-run: asynchronous clear, then stay idle without a load
    step(1, 4'd9, 1, 0, 4'd9, 1, 0, 0, "mid_load");
    step(0, 4'd0, 1, 0, 4'd8, 1, 0, 0, "mid_run1");
    step(0, 4'd0, 1, 0, 4'd7, 1, 0, 0, "mid_run2");
    step(0, 4'd0, 1, 0, 4'd6, 1, 0, 0, "mid_run3");
    #2 i_rst_n = 1'b0;
    #1;
    q.push_back('{c: 4'd0, b: 1'b0, e: 1'b0, t: 1'b0});
    chk("async_clear");
    #2 i_rst_n = 1'b1;
    step(0, 4'd0, 1, 0, 4'd0, 0, 0, 0, "post_rst1");
    step(0, 4'd0, 1, 1, 4'd0, 0, 0, 0, "post_rst2");

    // One-shot from 5
    step(1, 4'd5, 1, 0, 4'd5, 1, 0, 0, "os_load");
    for (int i = 4; i >= 1; i--) step(0, 4'd0, 1, 0, 4'(i), 1, 0, 0, "os_dec");
    step(0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "os_term");
    for (int i = 0; i < 10; i++) step(0, 4'd0, 1, i[0], 4'd0, 0, 1, 0, "os_hold");

    // Periodic from 3: tc on every reload, four pulses in 12 cycles
    step(1, 4'd3, 1, 1, 4'd3, 1, 0, 0, "per_load");
    for (int i = 0; i < 12; i++) begin
      cexp = (i % 3 == 0) ? 4'd2 : (i % 3 == 1) ? 4'd1 : 4'd3;
      step(0, 4'd0, 1, 1, cexp, 1, 0, (i % 3 == 2), "per_run");
    end

    // Enable gating from 4
    en_seq = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    step(1, 4'd4, 1, 0, 4'd4, 1, 0, 0, "en_load");
    step(0, 4'd0, en_seq[0][0], 0, 4'd3, 1, 0, 0, "en_1");
    step(0, 4'd0, en_seq[1][0], 0, 4'd3, 1, 0, 0, "en_0a");
    step(0, 4'd0, en_seq[2][0], 0, 4'd3, 1, 0, 0, "en_0b");
    step(0, 4'd0, en_seq[3][0], 0, 4'd2, 1, 0, 0, "en_1a");
    step(0, 4'd0, en_seq[4][0], 0, 4'd1, 1, 0, 0, "en_1b");
    step(0, 4'd0, en_seq[5][0], 0, 4'd0, 0, 1, 1, "en_term");

    // Load beats terminal count; load of zero goes idle
    step(1, 4'd2, 1, 1, 4'd2, 1, 0, 0, "pri_load");
    step(0, 4'd0, 1, 1, 4'd1, 1, 0, 0, "pri_at1");
    step(1, 4'd7, 1, 1, 4'd7, 1, 0, 0, "pri_reload7");
    step(1, 4'd0, 1, 1, 4'd0, 0, 0, 0, "pri_load0");
    step(0, 4'd0, 1, 1, 4'd0, 0, 0, 0, "pri_idle");

    // Pause on the terminal value never emits tc; mid-run mode change applies at terminal
    step(1, 4'd2, 1, 1, 4'd2, 1, 0, 0, "mode_load");
    step(0, 4'd0, 1, 0, 4'd1, 1, 0, 0, "mode_dec");
    step(0, 4'd0, 0, 0, 4'd1, 1, 0, 0, "mode_pause");
    step(0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "mode_term");

    // Maximum value, one-shot: 15 enabled cycles to tc
    step(1, 4'd15, 1, 0, 4'd15, 1, 0, 0, "max_load");
    for (int i = 14; i >= 1; i--) step(0, 4'd0, 1, 0, 4'(i), 1, 0, 0, "max_dec");
    step(0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "max_term");
    step(0, 4'd0, 1, 0, 4'd0, 0, 1, 0, "max_hold");
    step(1, 4'd3, 0, 0, 4'd3, 1, 0, 0, "load_clr_exp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
